operand_feeder: RTL and testbench
=================================

// Module: operand_feeder
// PURPOSE
//   Upstream stage of the encode datapath. Buffers an 8-bit byte stream in a small FIFO and pairs bytes (A, B).
//   Drives the start/data_in protocol of the encode FSM:
//   - start high with A on data_out for one cycle,
//   - then B on data_out for the next cycle,
//   - then waits for the FSM's done before issuing the next pair.
// PARAMETERS
//   DATA_W       8    byte width on in_data/data_out
//   DEPTH        8    FIFO entries; power of two, >=2
//   WDOG_CYCLES  16   watchdog limit in WAIT_DONE (used only with OPF_WDOG_EN)
// PORTS
//   clk         in   1                  single clock, rising edge
//   rst         in   1                  asynchronous, active-high reset
//   in_valid    in   1                  upstream byte valid
//   in_ready    out  1                  = !full; byte accepted when in_valid & in_ready at clk edge
//   in_data     in   DATA_W             upstream byte
//   start       out  1                  registered; to encode FSM start
//   data_out    out  DATA_W             registered; to encode FSM data_in
//   done_in     in   1                  encode FSM done
//   busy        out  1                  state != IDLE
//   fifo_count  out  $clog2(DEPTH)+1    bytes currently buffered
//   op_count    out  16                 completed pairs, wraps 0xFFFF->0
//   wdog_err    out  1                  sticky watchdog flag
// BEHAVIOUR
//   Reset (async, immediate, any state):
//   - state=IDLE; FIFO flushed (pointers 0, fifo_count=0).
//   - start=0, data_out=0, op_count=0, wdog_err=0; in_ready=1 after reset.
//   FIFO:
//   - circular; read/write pointers wrap at DEPTH.
//   - Push when in_valid&in_ready; pop only on FSM issue edges.
//   - Push+pop in the same cycle: count unchanged.
//   - in_ready derives from the registered count; a full FIFO refuses a push even if a pop occurs that cycle.
//   FSM (IDLE, ISSUE_A, ISSUE_B, WAIT_DONE):
//   - IDLE: if fifo_count>=2 -> ISSUE_A; at that edge start<=1, data_out<=head, pop. Otherwise hold; start=0.
//   - ISSUE_A (1 cycle): start=1, data_out=A. -> ISSUE_B; at that edge start<=0, data_out<=head, pop.
//   - ISSUE_B (1 cycle): start=0, data_out=B. -> WAIT_DONE.
//   - WAIT_DONE: done_in=1 -> IDLE and op_count+1. Otherwise hold.
//   - data_out holds B after ISSUE_B until the next launch.
//   - Pair period with the encode FSM is exactly 9 cycles:
//     start at t0, done_in at t7, back to IDLE at t8, next start at t9.
//   - done_in outside WAIT_DONE is ignored.
//   - A lone odd byte stays buffered until its partner arrives.
//   - Launch condition uses the registered fifo_count; the byte pushed in the IDLE decision cycle does not count.
// CONFIGURATION
//   OPF_WDOG_EN defined:
//   - 8-bit-min counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
//   - If it reaches WDOG_CYCLES with done_in still 0: wdog_err<=1 (sticky until rst), state->IDLE, op_count unchanged.
//   OPF_WDOG_EN undefined:
//   - no counter; WAIT_DONE waits forever; wdog_err tied 0.
// TESTING
//   1 Reset then push 0x12,0x34 -> start=1/data_out=0x12 for one cycle, then data_out=0x34/start=0; busy=1; fifo_count 2->0.
//   2 Encode FSM model returns done 6 cycles after ISSUE_B; push 6 bytes back-to-back
//     -> starts spaced 9 cycles; op_count=3; data_out sequence pairs in order.
//   3 Fill 8 bytes with no done -> in_ready=0 at count 8; extra in_valid byte dropped;
//     after pop of the next pair, in_ready returns to 1.
//   4 Push 3 bytes -> one pair issued; third byte held with fifo_count=1; push one more -> second pair issued.
//   5 Assert rst during ISSUE_B -> start=0, data_out=0, fifo_count=0, busy=0 immediately, without waiting for clk.
//   6 OPF_WDOG_EN defined, done_in held 0 -> wdog_err=1 after 16 WAIT_DONE cycles, then IDLE.
//     Undefined: stays in WAIT_DONE, wdog_err=0.

Source files
------------

// File: rtl/operand_feeder.sv
// Pairs buffered bytes into start/A, B launches for the encode FSM; 1-cycle issue latency, in_ready drops when the FIFO is full.
// Optional watchdog on the done wait enabled by defining OPF_WDOG_EN.
module operand_feeder #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int WDOG_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     start,
  output logic [DATA_W-1:0]        data_out,
  input  logic                     done_in,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              op_count,
  output logic                     wdog_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE_A,
    S_ISSUE_B,
    S_WAIT_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_start;
  logic [DATA_W-1:0]   r_data;
  logic [15:0]         r_op_count;
  logic                w_push;
  logic                w_pop;
  logic                w_op_done;
  logic [DATA_W-1:0]   w_head;

  // Readiness comes from the registered count only, so a full FIFO refuses even on a pop cycle.
  assign in_ready   = (r_count != CW'(DEPTH));
  assign w_push     = in_valid & in_ready;
  assign w_head     = r_mem[r_rptr];
  assign start      = r_start;
  assign data_out   = r_data;
  assign busy       = (r_state != S_IDLE);
  assign fifo_count = r_count;
  assign op_count   = r_op_count;

`ifdef OPF_WDOG_EN
  localparam int WW = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;

  logic [WW-1:0] r_wdog_cnt;
  logic          r_wdog_err;
  logic          w_wdog_trip;

  assign w_wdog_trip = (r_state == S_WAIT_DONE) && !done_in &&
                       (r_wdog_cnt == WW'(WDOG_CYCLES - 1));
  assign wdog_err    = r_wdog_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE_B) begin
        r_wdog_cnt <= '0;
      end else if (r_state == S_WAIT_DONE) begin
        r_wdog_cnt <= r_wdog_cnt + WW'(1);
      end
      if (w_wdog_trip) begin
        r_wdog_err <= 1'b1;
      end
    end
  end
`else
  logic w_unused_wdog;
  assign w_unused_wdog = |WDOG_CYCLES;
  assign wdog_err      = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_op_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count >= CW'(2)) begin
          w_next = S_ISSUE_A;
          w_pop  = 1'b1;
        end
      end
      S_ISSUE_A: begin
        w_next = S_ISSUE_B;
        w_pop  = 1'b1;
      end
      S_ISSUE_B: begin
        w_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (done_in) begin
          w_next    = S_IDLE;
          w_op_done = 1'b1;
`ifdef OPF_WDOG_EN
        end else if (w_wdog_trip) begin
          w_next = S_IDLE;
`endif
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_start    <= 1'b0;
      r_data     <= '0;
      r_op_count <= '0;
    end else begin
      r_state <= w_next;
      r_start <= (r_state == S_IDLE) && w_pop;
      if (w_pop) begin
        r_data <= w_head;
      end
      if (w_op_done) begin
        r_op_count <= r_op_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_operand_feeder.sv
module tb_operand_feeder;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int WDOG  = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          start;
  logic [DW-1:0] data_out;
  logic          done_in = 1'b0;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic [15:0]   op_count;
  logic          wdog_err;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_mode = 0;   // 0 never done, 1 encode-FSM model, 2 random, 3 always done
  time st_q[$];

  always #5 clk = ~clk;

  operand_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .start(start), .data_out(data_out), .done_in(done_in), .busy(busy),
    .fifo_count(fifo_count), .op_count(op_count), .wdog_err(wdog_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus "cycles since launch".
  logic [DW-1:0] mq[$];
  int            m_phase;   // -1 idle, 0 A cycle, 1 B cycle, 2 waiting for done
  int            m_wait;
  logic          m_start;
  logic [DW-1:0] m_data;
  logic [15:0]   m_ops;
  logic          m_err;

  initial begin
    m_phase = -1; m_wait = 0; m_start = 0; m_data = '0; m_ops = '0; m_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        m_phase = -1; m_wait = 0; m_start = 0; m_data = '0; m_ops = '0; m_err = 0;
      end
      n_checks++;
      if (start !== m_start || data_out !== m_data || busy !== (m_phase != -1) ||
          fifo_count !== CW'(mq.size()) || in_ready !== (mq.size() < DEPTH) ||
          op_count !== m_ops || wdog_err !== m_err) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got/exp start=%b/%b data=%h/%h busy=%b/%b cnt=%0d/%0d rdy=%b/%b ops=%0d/%0d wdog=%b/%b",
                 $time, start, m_start, data_out, m_data, busy, (m_phase != -1),
                 fifo_count, mq.size(), in_ready, (mq.size() < DEPTH), op_count, m_ops, wdog_err, m_err);
      end
      if (!rst) begin
        bit acc;
        acc = in_valid && (mq.size() < DEPTH);
        m_start = 1'b0;
        if (m_phase == -1) begin
          if (mq.size() >= 2) begin
            m_data = mq.pop_front(); m_start = 1'b1; m_phase = 0;
          end
        end else if (m_phase == 0) begin
          m_data = mq.pop_front(); m_phase = 1;
        end else if (m_phase == 1) begin
          m_phase = 2; m_wait = 0;
        end else begin
          if (done_in) begin
            m_ops = m_ops + 16'd1; m_phase = -1;
          end else begin
`ifdef OPF_WDOG_EN
            m_wait++;
            if (m_wait == WDOG) begin
              m_err = 1'b1; m_phase = -1;
            end
`endif
          end
        end
        if (acc) mq.push_back(in_data);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (start === 1'b1) st_q.push_back($time);
    end
  end

  // Encode FSM stand-in: in mode 1, done_in pulses 7 cycles after start.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      case (resp_mode)
        1: begin
          if (cnt > 0) begin cnt--; done_in = (cnt == 0); end
          else done_in = 1'b0;
          if (start === 1'b1) cnt = 7;
        end
        2: begin done_in = ($urandom_range(0, 3) == 0); cnt = 0; end
        3: begin done_in = 1'b1; cnt = 0; end
        default: begin done_in = 1'b0; cnt = 0; end
      endcase
    end
  end

  task automatic push_byte(input logic [DW-1:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (!(busy === 1'b0 && fifo_count < CW'(2)) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_idle_timeout"}, 64'(k < budget), 64'd1);
  endtask

  task automatic wait_start(input string name, input int budget);
    int k;
    k = 0;
    while (start !== 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_start_timeout"}, 64'(k < budget), 64'd1);
  endtask

  initial begin
    logic [15:0] base;
    int          s0;
    #1 rst = 1'b1;
    resp_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start", 64'(start), 64'd0);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_cnt", 64'(fifo_count), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_busy_ops_wdog", {busy, op_count, wdog_err}, 64'd0);
    rst = 1'b0;

    // Single pair 0x12, 0x34
    push_byte(8'h12);
    push_byte(8'h34);
    check("t1_cnt2", 64'(fifo_count), 64'd2);
    check("t1_start_low", 64'(start), 64'd0);
    @(posedge clk); #1;
    check("t1_a", {start, busy, data_out}, {1'b1, 1'b1, 8'h12});
    check("t1_cnt1", 64'(fifo_count), 64'd1);
    @(posedge clk); #1;
    check("t1_b", {start, busy, data_out}, {1'b0, 1'b1, 8'h34});
    check("t1_cnt0", 64'(fifo_count), 64'd0);
    wait_idle("t1", 40);
    check("t1_ops", 64'(op_count), 64'd1);
    check("t1_hold_b", 64'(data_out), 64'h34);

    // Six back-to-back bytes, 9-cycle pair period
    base = op_count;
    s0   = st_q.size();
    for (int i = 0; i < 6; i++) push_byte(8'(8'h50 + i * 7));
    wait_idle("t2", 100);
    check("t2_ops", 64'(op_count - base), 64'd3);
    check("t2_nstarts", 64'(st_q.size() - s0), 64'd3);
    if (st_q.size() - s0 == 3) begin
      check("t2_gap0", 64'(st_q[s0 + 1] - st_q[s0]), 64'd90);
      check("t2_gap1", 64'(st_q[s0 + 2] - st_q[s0 + 1]), 64'd90);
    end

    // Fill to full with no done; extra byte dropped
    resp_mode = 0;
    for (int i = 0; i < 10; i++) push_byte(8'(8'h40 + i));
    check("t3_full_cnt", 64'(fifo_count), 64'd8);
    check("t3_not_ready", 64'(in_ready), 64'd0);
    push_byte(8'hEE);
    check("t3_drop_cnt", 64'(fifo_count), 64'd8);
    check("t3_busy", 64'(busy), 64'd1);
    resp_mode = 3;
    begin
      int k;
      k = 0;
      while (in_ready !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
      check("t3_ready_back", 64'(in_ready), 64'd1);
      check("t3_cnt7", 64'(fifo_count), 64'd7);
    end
    wait_idle("t3", 80);
    resp_mode = 0;
    check("t3_drained", 64'(fifo_count), 64'd0);

    // Odd byte held until its partner arrives
    resp_mode = 1;
    base = op_count;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    wait_idle("t4a", 40);
    check("t4_odd_held", 64'(fifo_count), 64'd1);
    push_byte(8'h04);
    wait_start("t4", 5);
    check("t4_a", 64'(data_out), 64'h03);
    wait_idle("t4b", 40);
    check("t4_ops", 64'(op_count - base), 64'd2);
    check("t4_cnt0", 64'(fifo_count), 64'd0);

    // Async reset during ISSUE_B
    resp_mode = 0;
    push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
    wait_start("t5", 5);
    @(posedge clk); #2;
    check("t5_b", {start, busy, data_out}, {1'b0, 1'b1, 8'hB2});
    check("t5_cnt1", 64'(fifo_count), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_async", {start, busy, data_out, 4'(fifo_count)}, {1'b0, 1'b0, 8'h00, 4'h0});
    check("t5_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Watchdog behaviour with done held low
    base = op_count;
    push_byte(8'h77); push_byte(8'h88);
    wait_start("t6", 5);
    repeat (17) @(posedge clk);
    #1;
    check("t6_before", {busy, wdog_err}, 2'b10);
    @(posedge clk); #1;
`ifdef OPF_WDOG_EN
    check("t6_trip", {busy, wdog_err}, 2'b01);
    repeat (5) @(posedge clk);
    #1;
    check("t6_sticky", 64'(wdog_err), 64'd1);
`else
    check("t6_hold", {busy, wdog_err}, 2'b10);
    repeat (30) @(posedge clk);
    #1;
    check("t6_forever", {busy, wdog_err}, 2'b10);
`endif
    check("t6_ops", 64'(op_count), 64'(base));

    // Randomized traffic with random done pulses
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    resp_mode = 3;
    wait_idle("rand", 200);
    resp_mode = 0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
